// File: rtl/ctrl_pkg.sv
// Types and defaults shared between the host-side sequencer and ctrl.
package ctrl_pkg;

  localparam int STEPW_DEF = 8;
  localparam int ADDRW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [ADDRW_DEF-1:0] in_addr;
    logic [ADDRW_DEF-1:0] out_addr;
  } cmd_t;

endpackage

// File: rtl/ctrl_addr_gen.sv
// Input/output address channels: base load on job start, stride accumulate per step.
module ctrl_addr_gen
  import ctrl_pkg::*;
#(
  parameter int ADDRW = ADDRW_DEF
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             load,
  input  logic             step,
  input  logic [ADDRW-1:0] in_base,
  input  logic [ADDRW-1:0] out_base,
  input  logic [ADDRW-1:0] stride,
  output logic [ADDRW-1:0] in_addr,
  output logic [ADDRW-1:0] out_addr
);

  logic [ADDRW-1:0] in_addr_q, in_addr_d;
  logic [ADDRW-1:0] out_addr_q, out_addr_d;
  logic [ADDRW-1:0] stride_q, stride_d;

  // Sums wrap silently at 2^ADDRW.
  always_comb begin
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;
    stride_d   = stride_q;
    if (load) begin
      in_addr_d  = in_base;
      out_addr_d = out_base;
      stride_d   = stride;
    end else if (step) begin
      in_addr_d  = in_addr_q + stride_q;
      out_addr_d = out_addr_q + stride_q;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      in_addr_q  <= '0;
      out_addr_q <= '0;
      stride_q   <= '0;
    end else begin
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
      stride_q   <= stride_d;
    end
  end

  assign in_addr  = in_addr_q;
  assign out_addr = out_addr_q;

endmodule

// File: rtl/ctrl_host_seq.sv
// Host-side sequencer: issues one timestep command per step to ctrl and waits for its ack.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | req high for step k, waiting for ack (timeout armed)
//   GAP   | one-cycle req-low gap before the next step
//   FIN   | job complete, done pulse
module ctrl_host_seq
  import ctrl_pkg::*;
#(
  parameter int STEPW   = STEPW_DEF,
  parameter int ADDRW   = ADDRW_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             start,
  input  logic             abort,
  input  logic [STEPW-1:0] num_step,
  input  logic [ADDRW-1:0] in_base,
  input  logic [ADDRW-1:0] out_base,
  input  logic [ADDRW-1:0] stride,
  output logic             req,
  output logic             req_first,
  output logic             req_last,
  output logic [ADDRW-1:0] req_in_addr,
  output logic [ADDRW-1:0] req_out_addr,
  input  logic             ack,
  output logic [STEPW-1:0] step_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [STEPW-1:0] k_q, k_d;
  logic [STEPW-1:0] num_step_q, num_step_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             addr_load, addr_step;
  logic             is_last;

  assign is_last = (k_q == num_step_q - STEPW'(1));

  // Down-counter hits zero after TIMEOUT unacked cycles in ISSUE; ack on that cycle still wins.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    num_step_d = num_step_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    addr_load  = 1'b0;
    addr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_step_d = num_step;
          k_d        = '0;
          err_d      = 1'b0;
          addr_load  = 1'b1;
          if (num_step != '0) begin
            state_d = ISSUE;
            tmo_d   = TMO_LOAD;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ack) begin
          if (is_last) begin
            state_d = FIN;
          end else begin
            k_d       = k_q + STEPW'(1);
            addr_step = 1'b1;
            state_d   = GAP;
          end
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
          tmo_d   = TMO_LOAD;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      num_step_q <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      num_step_q <= num_step_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  ctrl_addr_gen #(
    .ADDRW(ADDRW)
  ) u_addr_gen (
    .clk     (clk),
    .xrst    (xrst),
    .load    (addr_load),
    .step    (addr_step),
    .in_base (in_base),
    .out_base(out_base),
    .stride  (stride),
    .in_addr (req_in_addr),
    .out_addr(req_out_addr)
  );

  assign req       = (state_q == ISSUE);
  assign req_first = req && (k_q == '0);
  assign req_last  = req && is_last;
  assign step_idx  = k_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = err_q;

endmodule

// File: tb/tb_ctrl_host_seq.sv
// Directed testbench for ctrl_host_seq with hand-computed expected values.
module tb_ctrl_host_seq;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_step = '0;
  logic [11:0] in_base = '0;
  logic [11:0] out_base = '0;
  logic [11:0] stride = '0;
  logic        req, req_first, req_last;
  logic [11:0] req_in_addr, req_out_addr;
  logic        ack = 1'b0;
  logic [7:0]  step_idx;
  logic        busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ctrl_host_seq #(
    .STEPW(8),
    .ADDRW(12),
    .TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .start       (start),
    .abort       (abort),
    .num_step    (num_step),
    .in_base     (in_base),
    .out_base    (out_base),
    .stride      (stride),
    .req         (req),
    .req_first   (req_first),
    .req_last    (req_last),
    .req_in_addr (req_in_addr),
    .req_out_addr(req_out_addr),
    .ack         (ack),
    .step_idx    (step_idx),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic [7:0] t, input logic [11:0] ib, input logic [11:0] ob,
                         input logic [11:0] st);
    num_step = t;
    in_base  = ib;
    out_base = ob;
    stride   = st;
  endtask

  // Vector of every output: {req,first,last,in_addr,out_addr,step_idx,busy,done,err}
  function automatic logic [37:0] outs();
    return {req, req_first, req_last, req_in_addr, req_out_addr, step_idx, busy, done, err};
  endfunction

  task automatic test_reset();
    xrst = 1'b0;
    #12;
    n_checks++;
    if (outs() !== 38'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got %h exp 0", outs());
    end
    @(negedge clk);
    xrst = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 38'd0) begin
      n_errors++;
      $display("FAIL reset_idle got %h exp 0", outs());
    end
  endtask

  task automatic test_basic();
    logic [11:0] ei, eo;
    logic [2:0]  exp_f;
    set_job(8'd3, 12'h100, 12'h800, 12'h020);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ei    = 12'h100 + 12'(k * 32);
      eo    = 12'h800 + 12'(k * 32);
      exp_f = {1'b1, (k == 0), (k == 2)};
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if ({req, req_first, req_last, req_in_addr, req_out_addr, step_idx, busy, done} !==
            {exp_f, ei, eo, 8'(k), 1'b1, 1'b0}) begin
          n_errors++;
          $display("FAIL basic_issue k=%0d c=%0d got req/f/l=%b%b%b in=%h out=%h idx=%0d exp f/l=%b in=%h out=%h",
                   k, c, req, req_first, req_last, req_in_addr, req_out_addr, step_idx, exp_f, ei, eo);
        end
        tick();
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      if (k < 2) begin
        n_checks++;
        if ({req, busy, done, step_idx} !== {1'b0, 1'b1, 1'b0, 8'(k + 1)}) begin
          n_errors++;
          $display("FAIL basic_gap k=%0d got req=%b busy=%b done=%b idx=%0d exp 0 1 0 %0d",
                   k, req, busy, done, step_idx, k + 1);
        end
        tick();
      end else begin
        n_checks++;
        if ({req, busy, done} !== 3'b011) begin
          n_errors++;
          $display("FAIL basic_done got req/busy/done=%b%b%b exp 011", req, busy, done);
        end
        tick();
        n_checks++;
        if ({req, busy, done, err} !== 4'b0000) begin
          n_errors++;
          $display("FAIL basic_idle got req/busy/done/err=%b%b%b%b exp 0000", req, busy, done, err);
        end
      end
    end
  endtask

  task automatic test_zero_steps();
    set_job(8'd0, 12'h123, 12'h456, 12'h001);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({req, busy, done} !== 3'b011) begin
      n_errors++;
      $display("FAIL zero_fin got req/busy/done=%b%b%b exp 011", req, busy, done);
    end
    tick();
    n_checks++;
    if ({req, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL zero_idle got req/busy/done=%b%b%b exp 000", req, busy, done);
    end
  endtask

  task automatic test_single_step();
    set_job(8'd1, 12'h0A0, 12'h0B0, 12'h010);
    start = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b1;
    n_checks++;
    if ({req, req_first, req_last, req_in_addr, req_out_addr} !== {3'b111, 12'h0A0, 12'h0B0}) begin
      n_errors++;
      $display("FAIL single_req got req/f/l=%b%b%b in=%h out=%h exp 111 0a0 0b0",
               req, req_first, req_last, req_in_addr, req_out_addr);
    end
    tick();
    ack = 1'b0;
    n_checks++;
    if ({req, done, busy} !== 3'b011) begin
      n_errors++;
      $display("FAIL single_done got req/done/busy=%b%b%b exp 011", req, done, busy);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit saw_done = 1'b0;
    set_job(8'd4, 12'h200, 12'h300, 12'h004);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    for (int c = 1; c < 16; c++) begin
      saw_done |= done;
      tick();
    end
    n_checks++;
    if ({req, err, step_idx, req_in_addr} !== {1'b1, 1'b0, 8'd1, 12'h204}) begin
      n_errors++;
      $display("FAIL tmo_before got req=%b err=%b idx=%0d in=%h exp 1 0 1 204",
               req, err, step_idx, req_in_addr);
    end
    tick();
    n_checks++;
    if ({req, err, busy, done} !== 4'b0100) begin
      n_errors++;
      $display("FAIL tmo_err got req/err/busy/done=%b%b%b%b exp 0100", req, err, busy, done);
    end
    tick();
    tick();
    n_checks++;
    if ({err, saw_done, done} !== 3'b100) begin
      n_errors++;
      $display("FAIL tmo_sticky got err=%b saw_done=%b done=%b exp 1 0 0", err, saw_done, done);
    end
    set_job(8'd1, 12'h000, 12'h000, 12'h000);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({err, req} !== 2'b01) begin
      n_errors++;
      $display("FAIL tmo_clear got err=%b req=%b exp 0 1", err, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    set_job(8'd5, 12'h400, 12'h500, 12'h008);
    start = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    // Start while busy must not re-latch any config.
    set_job(8'd2, 12'hF00, 12'hE00, 12'h100);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({req, req_in_addr, req_out_addr, step_idx, req_last} !== {1'b1, 12'h408, 12'h508, 8'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL abort_busy_start got req=%b in=%h out=%h idx=%0d last=%b exp 1 408 508 1 0",
               req, req_in_addr, req_out_addr, step_idx, req_last);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_checks++;
    if ({req, step_idx, req_in_addr, req_last} !== {1'b1, 8'd2, 12'h410, 1'b0}) begin
      n_errors++;
      $display("FAIL abort_step2 got req=%b idx=%0d in=%h last=%b exp 1 2 410 0",
               req, step_idx, req_in_addr, req_last);
    end
    abort = 1'b1;
    ack   = 1'b1;
    tick();
    abort = 1'b0;
    ack   = 1'b0;
    n_checks++;
    if ({req, busy, done, step_idx, err} !== {3'b000, 8'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL abort_idle got req/busy/done=%b%b%b idx=%0d err=%b exp 000 2 0",
               req, busy, done, step_idx, err);
    end
    tick();
    n_checks++;
    if ({busy, done, req} !== 3'b000) begin
      n_errors++;
      $display("FAIL abort_no_done got busy/done/req=%b%b%b exp 000", busy, done, req);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [11:0] ei, eo;
    set_job(8'd3, 12'h002, 12'h010, 12'hFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ei = 12'h002 - 12'(k);
      eo = 12'h010 - 12'(k);
      n_checks++;
      if ({req, req_in_addr, req_out_addr} !== {1'b1, ei, eo}) begin
        n_errors++;
        $display("FAIL wrap_addr k=%0d got req=%b in=%h out=%h exp 1 %h %h",
                 k, req, req_in_addr, req_out_addr, ei, eo);
      end
      if (k < 2) begin
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
      end
    end
    #2;
    xrst = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 38'd0) begin
      n_errors++;
      $display("FAIL xrst_mid got %h exp 0", outs());
    end
    @(negedge clk);
    xrst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({req, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL xrst_after got req/busy/done=%b%b%b exp 000", req, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_single_step();
    test_timeout();
    test_abort();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
